// File: rtl/fsk_modulator.sv
// FSK transmitter: frames bytes as start/8 data (LSB first)/stop and renders each bit as a mark or space tone.
// Define FSK_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fsk_modulator #(
  parameter int BIT_CYCLES = 64,
  parameter int MARK_HALF  = 1,
  parameter int SPACE_HALF = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       signal_out,
  output logic       busy
);

  localparam int MAX_HALF = (MARK_HALF > SPACE_HALF) ? MARK_HALF : SPACE_HALF;
  localparam int HCW      = $clog2(MAX_HALF) + 1;
  localparam int BCW      = $clog2(BIT_CYCLES);
  localparam logic [HCW-1:0] MARK_LAST  = HCW'(MARK_HALF - 1);
  localparam logic [HCW-1:0] SPACE_LAST = HCW'(SPACE_HALF - 1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(BIT_CYCLES - 1);

`ifdef FSK_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [HCW-1:0] half_cnt_q, half_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           signal_q, signal_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
`ifdef FSK_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic           bit_end;
  logic           accept;
  logic           tone_mark;
  logic [HCW-1:0] half_last;
  logic           toggle;

  assign bit_end   = (bit_cnt_q == BIT_LAST);
  assign accept    = (state_q == IDLE) && valid_in;
  assign half_last = tone_mark ? MARK_LAST : SPACE_LAST;
  assign toggle    = (half_cnt_q == half_last);

  always_ff @(posedge sysclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (valid_in) state_d = START;
      START:  if (bit_end) state_d = DATA;
`ifdef FSK_PARITY_EN
      DATA:   if (bit_end && bit_idx_q == 3'd7) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:   if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
`endif
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tone_mark = 1'b0;
    case (state_q)
      DATA:   tone_mark = shift_q[0];
`ifdef FSK_PARITY_EN
      PARITY: tone_mark = parity_q;
`endif
      STOP:   tone_mark = 1'b1;
      default: tone_mark = 1'b0;
    endcase
  end

  // Counters and shift register; the shift register only moves at data-bit boundaries.
  always_comb begin
    bit_cnt_d  = '0;
    half_cnt_d = '0;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
`ifdef FSK_PARITY_EN
    parity_d   = parity_q;
`endif
    if (state_q == IDLE) begin
      bit_idx_d = 3'd0;
      if (accept) begin
        shift_d = data_in;
`ifdef FSK_PARITY_EN
        parity_d = ^data_in;
`endif
      end
    end else begin
      bit_cnt_d  = bit_end ? '0 : bit_cnt_q + BCW'(1);
      half_cnt_d = (toggle || bit_end) ? '0 : half_cnt_q + HCW'(1);
      if (state_q == DATA && bit_end) begin
        bit_idx_d = bit_idx_q + 3'd1;
        shift_d   = {1'b0, shift_q[7:1]};
      end
    end
  end

  // Outputs are registered from the next state; accept forces the first start-bit low.
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    if (state_d == IDLE)      signal_d = 1'b1;
    else if (state_q == IDLE) signal_d = 1'b0;
    else                      signal_d = signal_q ^ toggle;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      signal_q   <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef FSK_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      half_cnt_q <= half_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      signal_q   <= signal_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef FSK_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign ready_out  = ready_q;
  assign busy       = busy_q;
  assign signal_out = signal_q;

endmodule

// File: tb/tb_fsk_modulator.sv
// Self-checking bench for fsk_modulator: per-cycle behavioural model plus directed edge-count checks.
module tb_fsk_modulator;

  localparam int BC = 64;
`ifdef FSK_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BC;

  logic       sysclk   = 1'b0;
  logic       reset    = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       ready_out, signal_out, busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 sysclk = ~sysclk;

  fsk_modulator #(.BIT_CYCLES(BC), .MARK_HALF(1), .SPACE_HALF(4)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .signal_out(signal_out),
    .busy      (busy)
  );

  // Frame bit at position idx: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic frameBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef FSK_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Every bit starts low and toggles every half cycles (1 for mark, 4 for space).
  function automatic logic expLevel(input logic [7:0] b, input int off);
    int half;
    half = frameBit(b, off / BC) ? 1 : 4;
    return (((off % BC) / half) % 2) == 1;
  endfunction

  bit         m_armed  = 1'b0;
  bit         m_active = 1'b0;
  int         m_off    = 0;
  logic [7:0] m_byte   = 8'h00;

  always @(posedge sysclk) begin
    m_armed = 1'b1;
    if (reset) begin
      m_active = 1'b0;
      m_off    = 0;
    end else if (!m_active) begin
      if (valid_in) begin
        m_active = 1'b1;
        m_off    = 0;
        m_byte   = data_in;
      end
    end else begin
      m_off++;
      if (m_off == FRAME) begin
        m_active = 1'b0;
        m_off    = 0;
      end
    end
  end

  always @(negedge sysclk) begin
    logic es, er, eb;
    if (m_armed) begin
      es = m_active ? expLevel(m_byte, m_off) : 1'b1;
      er = !m_active;
      eb = m_active;
      vectors++;
      if (signal_out !== es || ready_out !== er || busy !== eb) begin
        miscompares++;
        if (miscompares <= 20)
          $display("[TB] FAIL model t=%0t sig/rdy/busy got %b%b%b want %b%b%b",
                   $time, signal_out, ready_out, busy, es, er, eb);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    @(negedge sysclk);
    valid_in = v;
    data_in  = d;
    reset    = r;
  endtask

  task automatic waitReady();
    int n = 0;
    while (ready_out !== 1'b1 && n < 2000) begin
      @(negedge sysclk);
      n++;
    end
    if (n >= 2000) checkOutput("wait_ready_timeout", 0, 1);
  endtask

  // Sends one byte and counts rising edges of the line in each bit window.
  task automatic sendAndCount(input string name, input logic [7:0] b, input int tab[NBITS],
                              output int cnt[NBITS]);
    logic prev, lvl;
    for (int i = 0; i < NBITS; i++) cnt[i] = 0;
    waitReady();
    applyStimulus(1'b1, b, 1'b0);
    applyStimulus(1'b0, ~b, 1'b0);
    prev = 1'b1;
    for (int off = 0; off < FRAME; off++) begin
      if (off > 0) @(negedge sysclk);
      lvl = signal_out;
      if (lvl && !prev) cnt[off / BC]++;
      prev = lvl;
    end
    @(negedge sysclk);
    checkOutput({name, "_end_signal"}, signal_out, 1);
    checkOutput({name, "_end_ready"}, ready_out, 1);
    checkOutput({name, "_end_busy"}, busy, 0);
    for (int i = 0; i < NBITS; i++)
      checkOutput($sformatf("%s_edges_bit%0d", name, i), cnt[i], tab[i]);
  endtask

`ifdef FSK_PARITY_EN
  int tab_a5[NBITS] = '{8, 32, 8, 32, 8, 8, 32, 8, 32, 8, 32};
  int tab_3c[NBITS] = '{8, 8, 8, 32, 32, 32, 32, 8, 8, 8, 32};
  int tab_07[NBITS] = '{8, 32, 32, 32, 8, 8, 8, 8, 8, 32, 32};
  int tab_03[NBITS] = '{8, 32, 32, 8, 8, 8, 8, 8, 8, 8, 32};
`else
  int tab_a5[NBITS] = '{8, 32, 8, 32, 8, 8, 32, 8, 32, 32};
  int tab_3c[NBITS] = '{8, 8, 8, 32, 32, 32, 32, 8, 8, 32};
`endif

  initial begin
    int   cnt[NBITS];
    int   edges;
    int   n;
    logic prev;

    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    edges = 0;
    prev  = signal_out;
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk);
      if (signal_out && !prev) edges++;
      if (!signal_out) edges++;
      prev = signal_out;
    end
    checkOutput("idle_edges", edges, 0);
    checkOutput("idle_ready", ready_out, 1);

    sendAndCount("a5", 8'hA5, tab_a5, cnt);

    // Held valid: second accept happens in the single idle cycle after the first frame.
    waitReady();
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("b2b_busy", busy, 1);
    n = 1;
    while (ready_out !== 1'b1 && n < 2000) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput("b2b_gap", n, FRAME + 1);
    @(negedge sysclk);
    checkOutput("b2b_second_ready", ready_out, 0);
    checkOutput("b2b_second_signal", signal_out, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitReady();

    applyStimulus(1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b0, 8'h3C, 1'b0);
    repeat (198) @(negedge sysclk);
    applyStimulus(1'b0, 8'h3C, 1'b1);
    applyStimulus(1'b0, 8'h3C, 1'b0);
    checkOutput("abort_signal", signal_out, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", ready_out, 1);
    sendAndCount("3c", 8'h3C, tab_3c, cnt);

    applyStimulus(1'b1, 8'h55, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("reset_wins_busy", busy, 0);
    @(negedge sysclk);
    checkOutput("reset_wins_idle", busy, 0);

`ifdef FSK_PARITY_EN
    sendAndCount("p07", 8'h07, tab_07, cnt);
    sendAndCount("p03", 8'h03, tab_03, cnt);
`endif

    repeat (12000)
      applyStimulus($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 4999) == 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitReady();
    @(negedge sysclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
